pipeline_hazard_controller: RTL and testbench

- Sequences the 5-stage MIPS pipeline: IF, ID, EX, MEM, WB.
- Drives PC write-enable, IF_ID hold/flush, ID_EX bubble and EX_MEM flush.
- Keeps a 3-entry scoreboard of in-flight destination registers (EX, MEM, WB) to detect RAW hazards. The current datapath has no register-file bypass.
- Also handles control-flow redirects: jumps decoded in ID, branches resolved in MEM.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_scoreboard.sv | 49 ++++
 rtl/pipeline_hazard_controller.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, forwarding
// select encodings and the hard-wired zero register.
package hazard_pkg;

  localparam int unsigned SB_REG_W = 5;
  localparam logic [SB_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic [SB_REG_W-1:0] dest;
    logic                mem_read;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '0;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // A producer only matters if it really writes a non-zero register.
  function automatic logic sb_hit(sb_entry_t e, logic [SB_REG_W-1:0] src, logic used);
    return used && e.valid && e.reg_write && (e.dest != REG_ZERO) && (e.dest == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry (EX, MEM, WB) in-flight destination scoreboard with branch squash
// and per-source match vectors. HAZARD_FORWARDING_EN adds the EX load-use hit.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  sb_entry_t           id_entry,
  input  logic                load_id,
  input  logic                squash,
  input  logic [SB_REG_W-1:0] rs,
  input  logic [SB_REG_W-1:0] rt,
  input  logic                uses_rs,
  input  logic                uses_rt,
  output logic [2:0]          rs_match,
  output logic [2:0]          rt_match
`ifdef HAZARD_FORWARDING_EN
  ,
  output logic                ex_load_hit
`endif
);

  sb_entry_t ex_entry, mem_entry, wb_entry;

  // A taken branch in MEM kills the EX instruction before it reaches MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_entry  <= SB_EMPTY;
      mem_entry <= SB_EMPTY;
      wb_entry  <= SB_EMPTY;
    end else begin
      wb_entry  <= mem_entry;
      mem_entry <= squash ? SB_EMPTY : ex_entry;
      ex_entry  <= load_id ? id_entry : SB_EMPTY;
    end
  end

  always_comb begin
    rs_match = {sb_hit(wb_entry, rs, uses_rs), sb_hit(mem_entry, rs, uses_rs),
                sb_hit(ex_entry, rs, uses_rs)};
    rt_match = {sb_hit(wb_entry, rt, uses_rt), sb_hit(mem_entry, rt, uses_rt),
                sb_hit(ex_entry, rt, uses_rt)};
  end

`ifdef HAZARD_FORWARDING_EN
  assign ex_load_hit = ex_entry.mem_read && (rs_match[0] || rt_match[0]);
`endif

endmodule

// File: rtl/pipeline_hazard_controller.sv
// 5-stage MIPS hazard controller: RAW stalls, ID jumps, MEM branch redirects and
// a saturating stall counter. HAZARD_FORWARDING_EN enables operand forwarding.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_reg_write,
  input  logic [REG_ADDR_W-1:0]  id_write_reg,
  input  logic                   id_mem_read,
  input  logic                   id_jump,
  input  logic                   mem_branch_taken,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   if_id_flush,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_flush,
  output logic                   stall_active,
  output logic [STALL_CNT_W-1:0] stall_count
`ifdef HAZARD_FORWARDING_EN
  ,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel
`endif
);

  sb_entry_t  id_entry;
  logic [2:0] rs_match, rt_match;
  logic       hz;

  always_comb begin
    id_entry           = SB_EMPTY;
    id_entry.valid     = id_valid;
    id_entry.reg_write = id_reg_write;
    id_entry.dest      = id_write_reg;
    id_entry.mem_read  = id_mem_read;
  end

`ifdef HAZARD_FORWARDING_EN
  logic ex_load_hit;
`endif

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .id_entry (id_entry),
    .load_id  (!id_ex_bubble),
    .squash   (mem_branch_taken),
    .rs       (id_rs),
    .rt       (id_rt),
    .uses_rs  (id_uses_rs),
    .uses_rt  (id_uses_rt),
    .rs_match (rs_match),
    .rt_match (rt_match)
`ifdef HAZARD_FORWARDING_EN
    ,
    .ex_load_hit (ex_load_hit)
`endif
  );

`ifdef HAZARD_FORWARDING_EN
  // Producers in EX or MEM select the EX_MEM path; WB-only matches use MEM_WB.
  function automatic logic [1:0] pick_fwd(logic [2:0] m);
    if (m[0] || m[1]) return FWD_EXMEM;
    if (m[2])         return FWD_MEMWB;
    return FWD_RF;
  endfunction

  assign hz        = id_valid && ex_load_hit;
  assign fwd_a_sel = id_valid ? pick_fwd(rs_match) : FWD_RF;
  assign fwd_b_sel = id_valid ? pick_fwd(rt_match) : FWD_RF;
`else
  assign hz = id_valid && ((|rs_match) || (|rt_match));
`endif

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_flush   = 1'b0;
    stall_active   = 1'b0;
    if (reset) begin
      if (mem_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (hz) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        stall_active   = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall_active && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: stimulus pushes expected outputs from an age-based model of
// in-flight producers; a negedge monitor pops and compares.
module tb_pipeline_hazard_controller;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic             id_jump, mem_branch_taken;
  logic [4:0]       id_rs, id_rt, id_write_reg;
  logic             pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
  logic             ex_mem_flush, stall_active;
  logic [CNT_W-1:0] stall_count;
`ifdef HAZARD_FORWARDING_EN
  logic [1:0]       fwd_a_sel, fwd_b_sel;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .STALL_CNT_W (CNT_W),
    .REG_ADDR_W  (5)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .id_reg_write     (id_reg_write),
    .id_write_reg     (id_write_reg),
    .id_mem_read      (id_mem_read),
    .id_jump          (id_jump),
    .mem_branch_taken (mem_branch_taken),
    .pc_write_en      (pc_write_en),
    .if_id_write_en   (if_id_write_en),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .ex_mem_flush     (ex_mem_flush),
    .stall_active     (stall_active),
    .stall_count      (stall_count)
`ifdef HAZARD_FORWARDING_EN
    ,
    .fwd_a_sel        (fwd_a_sel),
    .fwd_b_sel        (fwd_b_sel)
`endif
  );

  // age = clock edges since the producer left ID (1 = EX, 2 = MEM, 3 = WB)
  typedef struct { int age; int dest; bit ld; } prod_t;
  typedef struct { int pc_we, ifid_we, ifid_flush, bubble, exf, stall, cnt, fa, fb; } exp_t;

  prod_t inflight[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    model_cnt = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{pc_we:1, ifid_we:1, ifid_flush:0, bubble:0, exf:0, stall:0, cnt:0, fa:0, fb:0};
    return e;
  endfunction

  task automatic model_cycle(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                             input bit rw, input int wr, input bit mr, input bit jmp, input bit br);
    exp_t  e;
    prod_t nxt[$];
    bit    hz = 0;
    int    rs_near = 0, rs_far = 0, rt_near = 0, rt_far = 0;
    foreach (inflight[i]) begin
      bit hit_rs, hit_rt;
      hit_rs = urs && (inflight[i].dest == rs);
      hit_rt = urt && (inflight[i].dest == rt);
      if (hit_rs) begin if (inflight[i].age <= 2) rs_near = 1; else rs_far = 1; end
      if (hit_rt) begin if (inflight[i].age <= 2) rt_near = 1; else rt_far = 1; end
`ifdef HAZARD_FORWARDING_EN
      if (v && inflight[i].ld && inflight[i].age == 1 && (hit_rs || hit_rt)) hz = 1;
`else
      if (v && (hit_rs || hit_rt)) hz = 1;
`endif
    end
    e = idle_exp();
    if (br) begin
      e.ifid_flush = 1; e.bubble = 1; e.exf = 1;
    end else if (hz) begin
      e.pc_we = 0; e.ifid_we = 0; e.bubble = 1; e.stall = 1;
    end else if (jmp) begin
      e.ifid_flush = 1;
    end
    e.cnt = model_cnt;
    if (v) begin
      e.fa = rs_near ? 1 : (rs_far ? 2 : 0);
      e.fb = rt_near ? 1 : (rt_far ? 2 : 0);
    end
    exp_q.push_back(e);
    if (e.stall && model_cnt < CNT_MAX) model_cnt++;
    foreach (inflight[i]) begin
      prod_t p;
      p = inflight[i];
      p.age++;
      if (p.age <= 3 && !(br && p.age == 2)) nxt.push_back(p);
    end
    if (!e.bubble && v && rw && wr != 0) nxt.push_back('{age:1, dest:wr, ld:mr});
    inflight = nxt;
  endtask

  task automatic set_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit rw, input int wr, input bit mr, input bit jmp, input bit br);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rs = urs; id_uses_rt = urt;
    id_reg_write = rw; id_write_reg = 5'(wr); id_mem_read = mr; id_jump = jmp;
    mem_branch_taken = br;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input int wr, input bit mr, input bit jmp, input bit br);
    @(posedge clk); #1;
    set_in(v, rs, rt, urs, urt, rw, wr, mr, jmp, br);
    model_cycle(v, rs, rt, urs, urt, rw, wr, mr, jmp, br);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset pulses between edges while the ID inputs would otherwise stall.
  task automatic reset_mid(input int rs, input int wr);
    @(posedge clk); #1;
    set_in(1, rs, 0, 1, 0, 1, wr, 0, 0, 0);
    #2 reset = 1'b0;
    inflight.delete();
    model_cnt = 0;
    model_cycle(1, rs, 0, 1, 0, 1, wr, 0, 0, 0);
    @(negedge clk); #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc_write_en",    int'(pc_write_en),    mon_e.pc_we);
      chk("if_id_write_en", int'(if_id_write_en), mon_e.ifid_we);
      chk("if_id_flush",    int'(if_id_flush),    mon_e.ifid_flush);
      chk("id_ex_bubble",   int'(id_ex_bubble),   mon_e.bubble);
      chk("ex_mem_flush",   int'(ex_mem_flush),   mon_e.exf);
      chk("stall_active",   int'(stall_active),   mon_e.stall);
      chk("stall_count",    int'(stall_count),    mon_e.cnt);
`ifdef HAZARD_FORWARDING_EN
      chk("fwd_a_sel",      int'(fwd_a_sel),      mon_e.fa);
      chk("fwd_b_sel",      int'(fwd_b_sel),      mon_e.fb);
`endif
    end
  end

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 exp_q.push_back(idle_exp());
    @(negedge clk); #1 reset = 1'b1;

    // producer $t0, consumer add $t1,$t0,$t2 held in ID while stalled
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 8, 10, 1, 1, 1, 9, 0, 0, 0);
    nops(3);
    // lw $t0 then add $t1,$t0,$t0
    drive(1, 0, 0, 1, 0, 1, 8, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
    nops(3);
    // $zero producer and consumer
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 1, 10, 0, 0, 0);
    nops(3);
    // taken branch over a RAW hazard squashes the producer
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    drive(1, 8, 8, 1, 1, 1, 9, 0, 0, 1);
    drive(1, 8, 8, 1, 1, 1, 9, 0, 0, 0);
    nops(3);
    // jr $ra waits for $ra, then one flush
    drive(1, 0, 0, 0, 0, 1, 31, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 31, 0, 1, 0, 0, 0, 0, 1, 0);
    nops(3);
    // long stall runs push the narrow counter into saturation
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
      nops(3);
    end
    // reset mid-stall
    drive(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    drive(1, 8, 0, 1, 0, 1, 9, 0, 0, 0);
    reset_mid(8, 9);
    nops(3);
    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 85, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 60,
            int'($urandom_range(0, 3)), $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 8);
    end
    nops(2);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
